// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state encoding shared by the multi-cycle ALU.
package alu_pkg;
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SUB_ALT = 4'b0011;
  localparam logic [3:0] ALU_PASSB   = 4'b0111;
  localparam logic [3:0] ALU_LSL     = 4'b1000;
  localparam logic [3:0] ALU_LSR     = 4'b1001;
  localparam logic [3:0] ALU_MUL     = 4'b1010;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier; done_o marks the cycle whose p_o is the final low-WIDTH product.
module alu_mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  // p_o already includes the current step so the caller can load it on the WIDTH-th edge
  assign p_o    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= p_o;
      cnt_q    <= cnt_q + 1'b1;
      busy_q   <= !done_o;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered result/flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 1010.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d, res, mul_p;
  logic             c_q, c_d, v_q, v_d, res_c, res_v;
  logic             accept, is_mul, mul_done;
  logic [WIDTH:0]   sum, diff;
  assign sum  = {1'b0, BusA} + {1'b0, BusB};
  assign diff = {1'b0, BusA} - {1'b0, BusB};
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (ALUCtrl)
      ALU_AND:   res = BusA & BusB;
      ALU_OR:    res = BusA | BusB;
      ALU_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      ALU_SUB, ALU_SUB_ALT: begin
        res   = diff[WIDTH-1:0];
        res_c = !diff[WIDTH];
        res_v = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      ALU_PASSB: res = BusB;
      ALU_LSL:   res = BusA << BusB[SHW-1:0];
      ALU_LSR:   res = BusA >> BusB[SHW-1:0];
      default:   ;
    endcase
  end
`ifdef ALU_MUL_EN
  assign is_mul = (ALUCtrl == ALU_MUL);
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .Clk     (Clk),
    .Reset_L (Reset_L),
    .start_i (accept && is_mul),
    .a_i     (BusA),
    .b_i     (BusB),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    c_d     = c_q;
    v_d     = v_q;
    InReady = (state_q == IDLE) || (state_q == DONE && OutReady);
    accept  = InValid && InReady;
    if (accept) state_d = is_mul ? BUSY : DONE;
    else if (state_q == DONE && OutReady) state_d = IDLE;
    if (accept && !is_mul) begin
      w_d = res;
      c_d = res_c;
      v_d = res_v;
    end
    if (state_q == BUSY && mul_done) begin
      state_d = DONE;
      w_d     = mul_p;
      c_d     = 1'b0;
      v_d     = 1'b0;
    end
  end
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      w_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end
  // Z and N are pure functions of the result register, so they stay registered
  assign OutValid = (state_q == DONE);
  assign BusW     = w_q;
  assign Zero     = (w_q == '0);
  assign Negative = w_q[WIDTH-1];
  assign Carry    = c_q;
  assign Overflow = v_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int W   = 64;
  localparam int SHW = $clog2(W);
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef struct packed {
    logic [W-1:0] w;
    logic z, n, c, v;
  } res_t;
  logic         Clk = 1'b0, Reset_L = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic         InReady, OutValid, Zero, Negative, Carry, Overflow;
  logic [W-1:0] BusA = '0, BusB = '0, BusW;
  logic [3:0]   ALUCtrl = '0;
  int tests = 0, fails = 0;
  always #5 Clk = ~Clk;
  alu_mc #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .OutValid(OutValid),
    .OutReady(OutReady), .BusW(BusW), .Zero(Zero), .Negative(Negative),
    .Carry(Carry), .Overflow(Overflow)
  );
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W:0] s;
    logic signed [W:0] t;
    r = '0;
    case (op)
      4'd0: r.w = a & b;
      4'd1: r.w = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r.w = s[W-1:0];
        r.c = s[W];
        t = $signed({a[W-1], a}) + $signed({b[W-1], b});
        r.v = (t != $signed({r.w[W-1], r.w}));
      end
      4'd3, 4'd6: begin
        r.w = a - b;
        r.c = (a >= b);
        t = $signed({a[W-1], a}) - $signed({b[W-1], b});
        r.v = (t != $signed({r.w[W-1], r.w}));
      end
      4'd7: r.w = b;
      4'd8: r.w = a << b[SHW-1:0];
      4'd9: r.w = a >> b[SHW-1:0];
`ifdef ALU_MUL_EN
      4'd10: r.w = a * b;
`endif
      default: ;
    endcase
    r.z = (r.w == '0);
    r.n = r.w[W-1];
    return r;
  endfunction
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    InValid = 1'b1; ALUCtrl = op; BusA = a; BusB = b;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge Clk);
      got = InReady;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL send_ready: InReady=%b required 1", InReady);
    end
    @(posedge Clk); #1;
    InValid = 1'b0; ALUCtrl = 4'($urandom);
    BusA = {$urandom, $urandom}; BusB = {$urandom, $urandom};
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!OutValid && lat < 300) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask
  task automatic test_reset;
    #12;
    tests++;
    if ({OutValid, BusW, Zero, Negative, Carry, Overflow} !== {1'b0, {W{1'b0}}, 4'b1000}) begin
      fails++;
      $display("FAIL reset_during: OutValid=%b BusW=%h ZNCV=%b%b%b%b", OutValid, BusW, Zero, Negative, Carry, Overflow);
    end
    #10 Reset_L = 1'b1;
    @(posedge Clk); #1;
    tests++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: InReady=%b OutValid=%b required 1 0", InReady, OutValid);
    end
    tests++;
    if ({BusW, Zero, Negative, Carry, Overflow} !== {{W{1'b0}}, 4'b1000}) begin
      fails++;
      $display("FAIL reset_out: BusW=%h ZNCV=%b%b%b%b required 0 1000", BusW, Zero, Negative, Carry, Overflow);
    end
  endtask
  task automatic test_add;
    OutReady = 1'b1;
    send(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    tests++;
    if (OutValid !== 1'b1) begin
      fails++;
      $display("FAIL add_latency: OutValid=%b required 1 one cycle after accept", OutValid);
    end
    tests++;
    if ({BusW, Zero, Negative, Carry, Overflow} !== {64'h8000_0000_0000_0000, 4'b0101}) begin
      fails++;
      $display("FAIL add_ovf: BusW=%h ZNCV=%b%b%b%b required 8000000000000000 0101", BusW, Zero, Negative, Carry, Overflow);
    end
    @(posedge Clk); #1;
    tests++;
    if (OutValid !== 1'b0) begin
      fails++;
      $display("FAIL add_consume: OutValid=%b required 0", OutValid);
    end
  endtask
  task automatic test_back_to_back;
    bit got = 0;
    OutReady = 1'b1;
    InValid = 1'b1; ALUCtrl = 4'b0110; BusA = 64'd5; BusB = 64'd5;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      got = InReady;
    end
    @(posedge Clk); #1;
    ALUCtrl = 4'b0011;
    tests++;
    if ({OutValid, InReady, BusW, Zero, Carry, Overflow} !== {2'b11, {W{1'b0}}, 3'b110}) begin
      fails++;
      $display("FAIL b2b_first: OV=%b IR=%b BusW=%h ZCV=%b%b%b required 1 1 0 110", OutValid, InReady, BusW, Zero, Carry, Overflow);
    end
    @(posedge Clk); #1;
    InValid = 1'b0; BusA = 64'd9;
    tests++;
    if ({OutValid, BusW, Zero, Carry, Overflow} !== {1'b1, {W{1'b0}}, 3'b110}) begin
      fails++;
      $display("FAIL b2b_second: OV=%b BusW=%h ZCV=%b%b%b required 1 0 110", OutValid, BusW, Zero, Carry, Overflow);
    end
    @(posedge Clk); #1;
    tests++;
    if (OutValid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: OutValid=%b required 0", OutValid);
    end
  endtask
  task automatic test_shift;
    OutReady = 1'b1;
    send(4'b1000, 64'h1, 64'hFFC0);
    tests++;
    if (BusW !== 64'h1 || OutValid !== 1'b1) begin
      fails++;
      $display("FAIL lsl_mask: BusW=%h OV=%b required 1 1", BusW, OutValid);
    end
    @(posedge Clk); #1;
    send(4'b1001, 64'h8000_0000_0000_0000, 64'd63);
    tests++;
    if (BusW !== 64'h1 || Negative !== 1'b0) begin
      fails++;
      $display("FAIL lsr_63: BusW=%h N=%b required 1 0", BusW, Negative);
    end
    @(posedge Clk); #1;
  endtask
  task automatic test_mul;
    int lat = 0, busy_ready = 0;
    OutReady = 1'b1;
    send(4'b1010, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    while (!OutValid && lat < 300) begin
      if (InReady !== 1'b0) busy_ready++;
      @(posedge Clk); #1;
      lat++;
    end
    tests++;
    if (lat != (MUL_EN ? W : 0) || busy_ready != 0) begin
      fails++;
      $display("FAIL mul_latency: cycles=%0d ready_while_busy=%0d required %0d 0", lat, busy_ready, MUL_EN ? W : 0);
    end
    tests++;
    if (BusW !== (MUL_EN ? 64'hFFFF_FFFE_0000_0001 : 64'h0) || Zero !== !MUL_EN) begin
      fails++;
      $display("FAIL mul_result: BusW=%h Z=%b required %h %b", BusW, Zero, MUL_EN ? 64'hFFFF_FFFE_0000_0001 : 64'h0, !MUL_EN);
    end
    @(posedge Clk); #1;
  endtask
  task automatic test_backpressure;
    OutReady = 1'b0;
    send(4'b0010, 64'd2, 64'd3);
    InValid = 1'b1; ALUCtrl = 4'b0001; BusA = 64'hF0; BusB = 64'h0F;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({OutValid, InReady, BusW} !== {2'b10, 64'd5}) begin
        fails++;
        $display("FAIL bp_hold%0d: OV=%b IR=%b BusW=%h required 1 0 5", i, OutValid, InReady, BusW);
      end
      @(posedge Clk); #1;
    end
    OutReady = 1'b1;
    #1;
    tests++;
    if (InReady !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready: InReady=%b required 1", InReady);
    end
    @(posedge Clk); #1;
    InValid = 1'b0;
    tests++;
    if (OutValid !== 1'b1 || BusW !== 64'hFF) begin
      fails++;
      $display("FAIL bp_queued: OV=%b BusW=%h required 1 ff", OutValid, BusW);
    end
    @(posedge Clk); #1;
  endtask
  task automatic test_mul_reset;
    OutReady = 1'b0;
    send(MUL_EN ? 4'b1010 : 4'b0010, 64'd5, 64'd7);
    repeat (19) @(posedge Clk);
    #3 Reset_L = 1'b0;
    #1;
    tests++;
    if ({OutValid, BusW, Zero, Negative, Carry, Overflow} !== {1'b0, {W{1'b0}}, 4'b1000}) begin
      fails++;
      $display("FAIL mulrst_clear: OV=%b BusW=%h ZNCV=%b%b%b%b required 0 0 1000", OutValid, BusW, Zero, Negative, Carry, Overflow);
    end
    #2 Reset_L = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b1;
    send(4'b0010, 64'd1, 64'd1);
    tests++;
    if (OutValid !== 1'b1 || BusW !== 64'd2) begin
      fails++;
      $display("FAIL mulrst_next: OV=%b BusW=%h required 1 2", OutValid, BusW);
    end
    @(posedge Clk); #1;
  endtask
  task automatic test_random;
    logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd4, 4'd5, 4'd11, 4'd15};
    logic [W-1:0] edges [5] = '{64'h0, {W{1'b1}}, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1};
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      logic [W-1:0] a, b;
      res_t e;
      int lat, hold;
      op = ops[$urandom_range(0, 12)];
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : {$urandom, $urandom};
      e = model(op, a, b);
      hold = $urandom_range(0, 3);
      OutReady = 1'b0;
      send(op, a, b);
      wait_out(lat);
      tests++;
      if (lat != ((MUL_EN && op == 4'd10) ? W : 0)) begin
        fails++;
        $display("FAIL rnd_lat%0d: op=%h cycles=%0d", k, op, lat);
      end
      repeat (hold) begin
        @(posedge Clk); #1;
      end
      tests++;
      if ({OutValid, BusW, Zero, Negative, Carry, Overflow} !== {1'b1, e.w, e.z, e.n, e.c, e.v}) begin
        fails++;
        $display("FAIL rnd_res%0d: op=%h a=%h b=%h got %h %b%b%b%b want %h %b%b%b%b", k, op, a, b,
                 BusW, Zero, Negative, Carry, Overflow, e.w, e.z, e.n, e.c, e.v);
      end
      OutReady = 1'b1;
      @(posedge Clk); #1;
      OutReady = 1'b0;
      tests++;
      if (OutValid !== 1'b0) begin
        fails++;
        $display("FAIL rnd_drain%0d: OutValid=%b required 0", k, OutValid);
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_mul();
    test_backpressure();
    test_mul_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the single-cycle datapath ALU, sitting between the register-read stage and writeback in the multi-cycle datapath. It accepts one operation per valid/ready handshake and returns a registered result with Zero/Negative/Carry/Overflow flags. The op set adds logical shifts and an optional iterative multiply. Backpressure on the result side stalls the unit rather than dropping results.

## Interface
- WIDTH, 64, operand/result width in bits (≥8, power of two)
- SHW, $clog2(WIDTH), shift-amount bits taken from BusB
- Clk  in  1  rising-edge clock
- Reset_L  in  1  reset, asynchronous, active-low; one clock, no other clock domains
- InValid  in  1  operation presented
- InReady  out  1  unit can accept an operation this cycle
- BusA  in  WIDTH  operand A
- BusB  in  WIDTH  operand B
- ALUCtrl  in  4  opcode
- OutValid  out  1  BusW/flags hold a result
- OutReady  in  1  consumer takes the result this cycle
- BusW  out  WIDTH  registered result
- Zero, Negative, Carry, Overflow  out  1 each  registered flags for BusW

## Operation
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 SUB (control-unit alias, identical to 0110); 0111 PassB; 1000 LSL (BusA << BusB[SHW-1:0]); 1001 LSR (logical); 1010 MUL (low WIDTH bits of BusA*BusB, unsigned). Any other opcode: BusW=0, flags Z=1, N=C=V=0.
- Shifts use only BusB[SHW-1:0]; upper BusB bits are ignored.
- Flags: Z = (BusW==0); N = BusW[WIDTH-1]; ADD: C = carry out of bit WIDTH-1, V = signed overflow; SUB: C = no-borrow (BusA ≥ BusB unsigned), V = signed overflow; all others C=V=0.
- Operands and opcode are captured on accept (InValid && InReady). Later changes on the inputs have no effect.
- FSM states:
  - IDLE: InReady=1. Accept of a non-MUL op computes the result into the output register and moves to DONE. Accept of MUL moves to BUSY.
  - BUSY: InReady=0. Runs the shift-add multiply for WIDTH cycles, then loads the result and moves to DONE.
  - DONE: OutValid=1. InReady = OutReady. If OutReady and InValid, the new op is accepted in the same cycle (non-MUL: stay DONE with the new result; MUL: go to BUSY). If OutReady without InValid, go to IDLE. If OutReady=0, hold BusW/flags stable.
- Reset, including mid-MUL: state IDLE, BusW=0, Zero=1, Negative=Carry=Overflow=0, OutValid=0, InReady=1 (once Reset_L is high). Any partial product is discarded.

## Timing
- Non-MUL latency: accept at edge N, OutValid=1 after edge N (one cycle). Sustained throughput of one op/cycle when OutReady is held high.
- MUL latency: accept at edge N, OutValid=1 after edge N+WIDTH (64 cycles at default). Throughput of one MUL per WIDTH+1 cycles at best.
- OutValid stays asserted, with BusW/flags unchanged, until a cycle with OutReady=1.
- No combinational path from InValid/BusA/BusB to any output. The only combinational path is OutReady→InReady, in DONE.

## Configuration
- ALU_MUL_EN defined: opcode 1010 runs the iterative multiplier as above.
- ALU_MUL_EN undefined: no multiplier logic is built. 1010 is an unknown opcode (BusW=0, Z=1, single-cycle), and the BUSY state is unreachable.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SUB_ALT, ALU_PASSB, ALU_LSL, ALU_LSR, ALU_MUL)
  - FSM state encoding (IDLE, BUSY, DONE)
- One sub-module, alu_mul_seq, holds the shift-add multiplier: start/done handshake, WIDTH-cycle counter, multiplicand/multiplier/accumulator registers. It is instantiated only under ALU_MUL_EN.

## Test plan
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1, OutReady=1 → OutValid one cycle later; BusW=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0.
- SUB 5−5 via 0110, then via 0011 back-to-back → two results on consecutive cycles, each BusW=0, Z=1, C=1, V=0.
- LSL 0x1 by BusB=0xFFC0 (low 6 bits = 0) → BusW=0x1. LSR 0x8000_0000_0000_0000 by 63 → BusW=0x1.
- MUL 0xFFFF_FFFF × 0xFFFF_FFFF (ALU_MUL_EN) → InReady=0 for 64 cycles, then BusW=0xFFFF_FFFE_0000_0001. Without ALU_MUL_EN: BusW=0, Z=1 after one cycle.
- Backpressure: ADD 2+3 with OutReady=0 for 5 cycles → BusW=5 held and InReady=0. On the OutReady=1 cycle, a queued OR 0xF0|0x0F is accepted; the next result is 0xFF.
- Reset_L pulsed low at cycle 20 of a MUL → immediate OutValid=0, BusW=0, Z=1. The next ADD 1+1 completes normally with BusW=2.
